// File: rtl/csa42_pkg.sv
// Shared constants and a reference row-total function for 4:2 carry-save stages.
// Latency: n/a (package only).
// Backpressure: n/a.
package csa42_pkg;

    localparam int CSA42_DEFAULT_WIDTH = 64;

    // Modular total of the four partial-product rows; sum_o + carry_o of a
    // correct stage must equal this, truncated to the stage width.
    function automatic logic [CSA42_DEFAULT_WIDTH-1:0] csa42_ref(
        input logic [CSA42_DEFAULT_WIDTH-1:0] row0,
        input logic [CSA42_DEFAULT_WIDTH-1:0] row1,
        input logic [CSA42_DEFAULT_WIDTH-1:0] row2,
        input logic [CSA42_DEFAULT_WIDTH-1:0] row3
    );
        return row0 + row1 + row2 + row3;
    endfunction

endpackage

// File: rtl/csa42_cell.sv
// One-bit 4:2 compressor: a,b,c,d plus horizontal cin reduced to s, k and cout.
// Latency: purely combinational.
// Backpressure: none.
module csa42_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic cin,
    output logic s,
    output logic k,
    output logic cout
);

    logic s1;

    // First full adder over a,b,c; its carry feeds the next bit, not this one,
    // so the chain never ripples more than one cell.
    assign s1   = a ^ b ^ c;
    assign cout = (a & b) | (a & c) | (b & c);

    // Second full adder folds in d and the neighbour's cout.
    assign s = s1 ^ d ^ cin;
    assign k = (s1 & d) | (s1 & cin) | (d & cin);

endmodule

// File: rtl/csa42_pipe_stage.sv
// Registered 4:2 carry-save stage: four WIDTH-bit rows in, sum row + pre-shifted carry row out.
// Latency: 1 cycle from input transfer to valid_o; 1 result/cycle sustained.
// Backpressure: valid/ready; CSA42_SKID_EN adds a skid slot with registered ready_o, else ready_o = ready_i || !valid_o.
module csa42_pipe_stage
    import csa42_pkg::*;
#(
    parameter int WIDTH = CSA42_DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] row0_i,
    input  logic [WIDTH-1:0] row1_i,
    input  logic [WIDTH-1:0] row2_i,
    input  logic [WIDTH-1:0] row3_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic [WIDTH-1:0] carry_o
);

    logic [WIDTH-1:0] s_w;
    logic [WIDTH-1:0] k_w;
    logic [WIDTH-1:0] cout_w;
    logic [WIDTH-1:0] cin_w;
    logic [WIDTH-1:0] nxt_sum;
    logic [WIDTH-1:0] nxt_carry;
    logic             unused_msb;

    logic             out_vld;
    logic [WIDTH-1:0] out_sum;
    logic [WIDTH-1:0] out_carry;
    logic             in_xfer;

    // Horizontal chain: each cell's first-adder carry becomes the next cell's cin.
    assign cin_w = {cout_w[WIDTH-2:0], 1'b0};

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_cell
            csa42_cell u_cell (
                .a    (row0_i[i]),
                .b    (row1_i[i]),
                .c    (row2_i[i]),
                .d    (row3_i[i]),
                .cin  (cin_w[i]),
                .s    (s_w[i]),
                .k    (k_w[i]),
                .cout (cout_w[i])
            );
        end
    endgenerate

    // Weight 2^WIDTH falls off the end of a modulo-2^WIDTH result.
    assign unused_msb = cout_w[WIDTH-1] ^ k_w[WIDTH-1];

    assign nxt_sum   = s_w;
    assign nxt_carry = {k_w[WIDTH-2:0], 1'b0};

    assign valid_o = out_vld;
    assign sum_o   = out_sum;
    assign carry_o = out_carry;

`ifdef CSA42_SKID_EN
    logic             skid_vld;
    logic [WIDTH-1:0] skid_sum;
    logic [WIDTH-1:0] skid_carry;
    logic             out_load;

    // ready_o comes straight from a flop so ready_i never reaches it combinationally.
    assign ready_o  = !skid_vld;
    assign in_xfer  = valid_i && !skid_vld;
    assign out_load = !out_vld || ready_i;

    // Output slot refills from the skid first (older), then from the input;
    // an input arriving while the output is held parks in the skid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_vld    <= 1'b0;
            out_sum    <= '0;
            out_carry  <= '0;
            skid_vld   <= 1'b0;
            skid_sum   <= '0;
            skid_carry <= '0;
        end else if (out_load) begin
            if (skid_vld) begin
                out_vld   <= 1'b1;
                out_sum   <= skid_sum;
                out_carry <= skid_carry;
                skid_vld  <= 1'b0;
            end else if (in_xfer) begin
                out_vld   <= 1'b1;
                out_sum   <= nxt_sum;
                out_carry <= nxt_carry;
            end else begin
                out_vld <= 1'b0;
            end
        end else if (in_xfer) begin
            skid_vld   <= 1'b1;
            skid_sum   <= nxt_sum;
            skid_carry <= nxt_carry;
        end
    end
`else
    // Accept whenever the single slot is empty or is being drained this cycle.
    assign ready_o = ready_i || !out_vld;
    assign in_xfer = valid_i && ready_o;

    // New result replaces the departing one; otherwise a drained slot empties.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_vld   <= 1'b0;
            out_sum   <= '0;
            out_carry <= '0;
        end else if (in_xfer) begin
            out_vld   <= 1'b1;
            out_sum   <= nxt_sum;
            out_carry <= nxt_carry;
        end else if (ready_i) begin
            out_vld <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_csa42_pipe_stage.sv
// Bench for csa42_pipe_stage: directed steps plus a random stream scored against a row-total queue.
// Latency: expects results one cycle after acceptance.
// Backpressure: drives ready_i directly; handshake checks follow CSA42_SKID_EN when defined.
module tb_csa42_pipe_stage;
    import csa42_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [63:0] row0_i, row1_i, row2_i, row3_i;
    logic        valid_o;
    logic        ready_i;
    logic [63:0] sum_o;
    logic [63:0] carry_o;

    logic        v8_i;
    logic        rdy8_o;
    logic [7:0]  r8_0, r8_1, r8_2, r8_3;
    logic        v8_o;
    logic        one = 1'b1;
    logic [7:0]  sum8, car8;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_acc = 0;
    int          n_del = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    csa42_pipe_stage #(.WIDTH(64)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .row0_i  (row0_i),
        .row1_i  (row1_i),
        .row2_i  (row2_i),
        .row3_i  (row3_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .sum_o   (sum_o),
        .carry_o (carry_o)
    );

    csa42_pipe_stage #(.WIDTH(8)) dut8 (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (v8_i),
        .ready_o (rdy8_o),
        .row0_i  (r8_0),
        .row1_i  (r8_1),
        .row2_i  (r8_2),
        .row3_i  (r8_3),
        .valid_o (v8_o),
        .ready_i (one),
        .sum_o   (sum8),
        .carry_o (car8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge with inputs already driven; scores the next
    // rising edge and returns at the following negedge.
    task automatic tick();
        logic        in_x, out_x;
        logic [63:0] s, c, e, r0, r1, r2, r3;
        #1;
        in_x  = valid_i && ready_o;
        out_x = valid_o && ready_i;
        s = sum_o;  c = carry_o;
        r0 = row0_i; r1 = row1_i; r2 = row2_i; r3 = row3_i;
        @(posedge clk);
        if (out_x) begin
            n_cmp++;
            assert (exp_q.size() != 0)
            else begin
                n_err++;
                $error("FAIL spurious_output: observed sum %h carry %h expected no result", s, c);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("invariant", s + c, e);
                check("carry_lsb", {63'd0, c[0]}, 64'd0);
                n_del++;
            end
        end
        if (in_x) begin
            exp_q.push_back(csa42_ref(r0, r1, r2, r3));
            n_acc++;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] pat[4];
        logic [7:0]  tot8;
        int          a0, d0, cyc;

        rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
        row0_i = '0; row1_i = '0; row2_i = '0; row3_i = '0;
        v8_i = 1'b0; r8_0 = '0; r8_1 = '0; r8_2 = '0; r8_3 = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_valid", {63'd0, valid_o}, 64'd0);
        check("reset_sum", sum_o, 64'd0);
        check("reset_carry", carry_o, 64'd0);
        check("reset_ready", {63'd0, ready_o}, 64'd1);
        check("reset_ready_w8", {63'd0, rdy8_o}, 64'd1);
        rst = 1'b0;

        // WIDTH=8: all rows 0x01
        v8_i = 1'b1; r8_0 = 8'h01; r8_1 = 8'h01; r8_2 = 8'h01; r8_3 = 8'h01;
        @(negedge clk);
        check("w8_ones_valid", {63'd0, v8_o}, 64'd1);
        check("w8_ones_sum", {56'd0, sum8}, 64'h02);
        check("w8_ones_carry", {56'd0, car8}, 64'h02);

        // WIDTH=8: all rows 0xFF
        r8_0 = 8'hFF; r8_1 = 8'hFF; r8_2 = 8'hFF; r8_3 = 8'hFF;
        @(negedge clk);
        tot8 = sum8 + car8;
        check("w8_ff_total", {56'd0, tot8}, 64'hFC);
        check("w8_ff_sum", {56'd0, sum8}, 64'hFE);
        check("w8_ff_carry", {56'd0, car8}, 64'hFE);
        v8_i = 1'b0;
        @(negedge clk);
        check("w8_drop_after_output", {63'd0, v8_o}, 64'd0);

        // WIDTH=64 directed patterns, one at a time with ready_i=1
        pat[0] = 64'h0000_0000_0000_0001;
        pat[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        pat[2] = 64'hAAAA_AAAA_5555_5555;
        pat[3] = 64'h8000_0000_0000_0000;
        ready_i = 1'b1;
        for (int p = 0; p < 4; p++) begin
            valid_i = 1'b1;
            row0_i = pat[p]; row1_i = pat[(p+1)%4]; row2_i = pat[(p+2)%4]; row3_i = ~pat[p];
            tick();
            valid_i = 1'b0;
            check("latency_valid", {63'd0, valid_o}, 64'd1);
            tick();
            check("drop_after_output", {63'd0, valid_o}, 64'd0);
        end

`ifdef CSA42_SKID_EN
        // Stall: exactly two results fit, ready_o falls after the second.
        a0 = n_acc;
        ready_i = 1'b0; valid_i = 1'b1;
        row0_i = 64'h11; row1_i = 64'h22; row2_i = 64'h33; row3_i = 64'h44;
        tick();
        check("skid_ready_after_first", {63'd0, ready_o}, 64'd1);
        row0_i = 64'h1000; row1_i = 64'h2000; row2_i = 64'h3000; row3_i = 64'h4000;
        tick();
        check("skid_ready_after_second", {63'd0, ready_o}, 64'd0);
        for (int j = 0; j < 3; j++) begin
            row0_i = 64'(j + 7);
            tick();
        end
        check("skid_accept_count", 64'(n_acc - a0), 64'd2);
        d0 = n_del;
        valid_i = 1'b0; ready_i = 1'b1;
        #1;
        check("skid_ready_registered", {63'd0, ready_o}, 64'd0);
        tick();
        check("skid_ready_after_drain", {63'd0, ready_o}, 64'd1);
        check("skid_second_in_output", {63'd0, valid_o}, 64'd1);
        tick();
        check("skid_empty_after_both", {63'd0, valid_o}, 64'd0);
        check("skid_deliver_count", 64'(n_del - d0), 64'd2);
`else
        // Single register: ready_o follows ready_i combinationally while full.
        ready_i = 1'b0; valid_i = 1'b1;
        row0_i = 64'h5; row1_i = 64'h6; row2_i = 64'h7; row3_i = 64'h8;
        tick();
        valid_i = 1'b0;
        #1;
        check("held_valid", {63'd0, valid_o}, 64'd1);
        check("ready_low_when_held", {63'd0, ready_o}, 64'd0);
        ready_i = 1'b1;
        #1;
        check("ready_follows_ready_i", {63'd0, ready_o}, 64'd1);
        tick();
`endif

        // Reset mid-stream while a result is held.
        ready_i = 1'b0; valid_i = 1'b1;
        row0_i = 64'h99; row1_i = 64'h1; row2_i = 64'h2; row3_i = 64'h3;
        tick();
        tick();
        check("pre_reset_valid", {63'd0, valid_o}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", {63'd0, valid_o}, 64'd0);
        check("midrst_sum", sum_o, 64'd0);
        check("midrst_carry", carry_o, 64'd0);
        check("midrst_ready", {63'd0, ready_o}, 64'd1);
        @(negedge clk);
        rst = 1'b0; valid_i = 1'b0;
        exp_q.delete();

        // Random back-to-back stream with 50% downstream stalls.
        a0 = n_acc;
        d0 = n_del;
        cyc = 0;
        while (n_acc - a0 < 10000 && cyc < 60000) begin
            valid_i = 1'b1;
            row0_i = {$urandom(), $urandom()};
            row1_i = {$urandom(), $urandom()};
            row2_i = {$urandom(), $urandom()};
            row3_i = {$urandom(), $urandom()};
            ready_i = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        check("random_accept_count", 64'(n_acc - a0), 64'd10000);
        valid_i = 1'b0; ready_i = 1'b1;
        cyc = 0;
        while ((exp_q.size() != 0 || valid_o) && cyc < 20) begin
            tick();
            cyc++;
        end
        check("random_drain_queue", 64'(exp_q.size()), 64'd0);
        check("random_deliver_count", 64'(n_del - d0), 64'd10000);
        check("final_valid", {63'd0, valid_o}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
